// File: rtl/adapter_dpb_xfer_pkg.sv
// Shared types and helpers for the dual-port BRAM / ping-pong FIFO transfer adapter.
package adapter_dpb_xfer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_SETUP,
    S_WR_ISSUE,
    S_WR_DRAIN,
    S_RD_SETUP,
    S_RD_XFER,
    S_DONE
  } xfer_state_t;

  localparam int unsigned MEM_LATENCY_MIN = 1;
  localparam int unsigned MEM_LATENCY_MAX = 4;

  function automatic int unsigned umin(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/adapter_dpb_rd_pipe.sv
// Port-B read valid shift register: din emerges on dout DEPTH cycles later; flush clears it.
module adapter_dpb_rd_pipe #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic din,
  output logic dout,
  output logic busy
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      sr <= '0;
    end else begin
      sr[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];
  assign busy = |sr;

endmodule

// File: rtl/adapter_dpb_ppfifo_xfer.sv
// Dual-port BRAM with a block-transfer engine between port B and the ping-pong FIFOs.
// Optional port-A address-stability tracker: ADAPTER_DPB_XFER_BRAM_VALID_EN.
module adapter_dpb_ppfifo_xfer
  import adapter_dpb_xfer_pkg::*;
#(
  parameter int unsigned MEM_DEPTH   = 10,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned SIZE_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start_wr_stb,
  input  logic                  i_start_rd_stb,
  input  logic                  i_cancel_stb,
  input  logic [MEM_DEPTH-1:0]  i_base_addr,
  input  logic [MEM_DEPTH:0]    i_xfer_len,
  output logic                  o_busy,
  output logic                  o_done_stb,
  output logic                  o_truncated,
  output logic [MEM_DEPTH:0]    o_word_count,
  output logic [31:0]           o_num_reads,
  output logic [31:0]           o_num_writes,
  input  logic                  i_bram_we,
  input  logic [MEM_DEPTH-1:0]  i_bram_addr,
  input  logic [DATA_WIDTH-1:0] i_bram_din,
  output logic [DATA_WIDTH-1:0] o_bram_dout,
  output logic                  o_bram_valid,
  input  logic [1:0]            i_write_ready,
  output logic [1:0]            o_write_activate,
  input  logic [SIZE_WIDTH-1:0] i_write_size,
  output logic                  o_write_stb,
  output logic [DATA_WIDTH-1:0] o_write_data,
  input  logic                  i_read_ready,
  output logic                  o_read_activate,
  input  logic [SIZE_WIDTH-1:0] i_read_size,
  input  logic [DATA_WIDTH-1:0] i_read_data,
  output logic                  o_read_stb
);

  localparam int unsigned MEM_SIZE = 1 << MEM_DEPTH;
  localparam int unsigned LW       = MEM_DEPTH + 1;
  localparam int unsigned CNT_W    = $clog2(MEM_LATENCY_MAX) + 1;

  if (MEM_LATENCY < MEM_LATENCY_MIN || MEM_LATENCY > MEM_LATENCY_MAX) begin : g_bad_latency
    $error("MEM_LATENCY out of range");
  end

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
  logic [DATA_WIDTH-1:0] a_pipe [MEM_LATENCY];
  logic [DATA_WIDTH-1:0] b_pipe [MEM_LATENCY];

  xfer_state_t           state;
  logic                  dir_wr;
  logic [MEM_DEPTH-1:0]  addr;
  logic [LW-1:0]         remaining;
  logic [LW-1:0]         chunk;
  logic [SIZE_WIDTH-1:0] pkt;
  logic [1:0]            write_act;
  logic                  read_act;
  logic                  rd_stb;
  logic                  done_stb;
  logic                  truncated;
  logic [LW-1:0]         word_count;
  logic [31:0]           num_reads;
  logic [31:0]           num_writes;

  logic          issue;
  logic          we_b;
  logic          pipe_busy;
  logic [LW-1:0] start_len;

  assign issue     = (state == S_WR_ISSUE) && (chunk != '0);
  assign we_b      = rd_stb && (remaining != '0);
  assign start_len = LW'(umin(32'(i_xfer_len), MEM_SIZE));

  always_ff @(posedge clk) begin
    if (i_bram_we) mem[i_bram_addr] <= i_bram_din;
    if (we_b)      mem[addr]        <= i_read_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
        a_pipe[i] <= '0;
        b_pipe[i] <= '0;
      end
    end else begin
      a_pipe[0] <= mem[i_bram_addr];
      b_pipe[0] <= mem[addr];
      for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
        a_pipe[i] <= a_pipe[i-1];
        b_pipe[i] <= b_pipe[i-1];
      end
    end
  end

  adapter_dpb_rd_pipe #(.DEPTH(MEM_LATENCY)) u_rd_pipe (
    .clk   (clk),
    .rst   (rst),
    .flush (i_cancel_stb),
    .din   (issue),
    .dout  (o_write_stb),
    .busy  (pipe_busy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      dir_wr     <= 1'b0;
      addr       <= '0;
      remaining  <= '0;
      chunk      <= '0;
      pkt        <= '0;
      write_act  <= '0;
      read_act   <= 1'b0;
      rd_stb     <= 1'b0;
      done_stb   <= 1'b0;
      truncated  <= 1'b0;
      word_count <= '0;
      num_reads  <= '0;
      num_writes <= '0;
    end else if (i_cancel_stb) begin
      state     <= S_IDLE;
      write_act <= '0;
      read_act  <= 1'b0;
      rd_stb    <= 1'b0;
      done_stb  <= 1'b0;
    end else begin
      done_stb <= 1'b0;
      if (o_write_stb) word_count <= word_count + 1'b1;
      case (state)
        S_IDLE: begin
          if (i_start_wr_stb || i_start_rd_stb) begin
            dir_wr     <= i_start_wr_stb;
            addr       <= i_base_addr;
            remaining  <= start_len;
            word_count <= '0;
            truncated  <= 1'b0;
            if (start_len == '0) begin
              state    <= S_DONE;
              done_stb <= 1'b1;
            end else begin
              state <= i_start_wr_stb ? S_WR_SETUP : S_RD_SETUP;
            end
          end
        end
        S_WR_SETUP: begin
          if (i_write_ready != '0 && write_act == '0) begin
            write_act <= i_write_ready[0] ? 2'b01 : 2'b10;
            chunk     <= LW'(umin(32'(remaining), 32'(i_write_size)));
            state     <= S_WR_ISSUE;
          end
        end
        S_WR_ISSUE: begin
          if (chunk != '0) begin
            addr      <= addr + 1'b1;
            remaining <= remaining - 1'b1;
            chunk     <= chunk - 1'b1;
          end
          if (chunk <= LW'(1)) state <= S_WR_DRAIN;
        end
        S_WR_DRAIN: begin
          if (!pipe_busy) begin
            write_act <= '0;
            if (remaining != '0) begin
              state <= S_WR_SETUP;
            end else begin
              state    <= S_DONE;
              done_stb <= 1'b1;
            end
          end
        end
        S_RD_SETUP: begin
          if (i_read_ready && !read_act) begin
            read_act <= 1'b1;
            pkt      <= i_read_size;
            rd_stb   <= (i_read_size != '0);
            state    <= S_RD_XFER;
          end
        end
        S_RD_XFER: begin
          // rd_stb is kept equal to (pkt != 0) so the pop strobe stays a plain register
          if (pkt != '0) begin
            pkt    <= pkt - 1'b1;
            rd_stb <= (pkt > SIZE_WIDTH'(1));
            if (remaining != '0) begin
              addr       <= addr + 1'b1;
              remaining  <= remaining - 1'b1;
              word_count <= word_count + 1'b1;
            end else begin
              truncated <= 1'b1;
            end
          end else begin
            read_act <= 1'b0;
            if (remaining != '0) begin
              state <= S_RD_SETUP;
            end else begin
              state    <= S_DONE;
              done_stb <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          if (dir_wr) num_writes <= num_writes + 1'b1;
          else        num_reads  <= num_reads + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_busy           = (state != S_IDLE);
  assign o_done_stb       = done_stb;
  assign o_truncated      = truncated;
  assign o_word_count     = word_count;
  assign o_num_reads      = num_reads;
  assign o_num_writes     = num_writes;
  assign o_write_activate = write_act;
  assign o_write_data     = b_pipe[MEM_LATENCY-1];
  assign o_read_activate  = read_act;
  assign o_read_stb       = rd_stb;
  assign o_bram_dout      = a_pipe[MEM_LATENCY-1];

`ifdef ADAPTER_DPB_XFER_BRAM_VALID_EN
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MEM_LATENCY - 1);

  logic [MEM_DEPTH-1:0] addr_prev;
  logic [CNT_W-1:0]     stable_cnt;

  // Saturates at MEM_LATENCY-1 so the combinational compare covers the change cycle itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_prev  <= '0;
      stable_cnt <= CNT_SAT;
    end else begin
      addr_prev <= i_bram_addr;
      if (i_bram_addr != addr_prev)  stable_cnt <= '0;
      else if (stable_cnt != CNT_SAT) stable_cnt <= stable_cnt + 1'b1;
    end
  end

  assign o_bram_valid = (i_bram_addr == addr_prev) && (stable_cnt == CNT_SAT);
`else
  assign o_bram_valid = 1'b1;
`endif

endmodule

// File: tb/tb_adapter_dpb_ppfifo_xfer.sv
// Directed self-checking bench for adapter_dpb_ppfifo_xfer (MEM_DEPTH=4, MEM_LATENCY=2).
module tb_adapter_dpb_ppfifo_xfer;

  localparam int MD = 4;
  localparam int DW = 32;
  localparam int ML = 2;
  localparam int SW = 24;
  localparam logic [31:0] PRE = 32'hC0DE_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start_wr_stb, i_start_rd_stb, i_cancel_stb;
  logic [MD-1:0] i_base_addr;
  logic [MD:0]   i_xfer_len;
  logic          o_busy, o_done_stb, o_truncated;
  logic [MD:0]   o_word_count;
  logic [31:0]   o_num_reads, o_num_writes;
  logic          i_bram_we;
  logic [MD-1:0] i_bram_addr;
  logic [DW-1:0] i_bram_din, o_bram_dout;
  logic          o_bram_valid;
  logic [1:0]    i_write_ready, o_write_activate;
  logic [SW-1:0] i_write_size;
  logic          o_write_stb;
  logic [DW-1:0] o_write_data;
  logic          i_read_ready, o_read_activate;
  logic [SW-1:0] i_read_size;
  logic [DW-1:0] i_read_data;
  logic          o_read_stb;

  int checks = 0;
  int errors = 0;

  adapter_dpb_ppfifo_xfer #(
    .MEM_DEPTH(MD), .DATA_WIDTH(DW), .MEM_LATENCY(ML), .SIZE_WIDTH(SW)
  ) dut (
    .clk(clk), .rst(rst),
    .i_start_wr_stb(i_start_wr_stb), .i_start_rd_stb(i_start_rd_stb),
    .i_cancel_stb(i_cancel_stb), .i_base_addr(i_base_addr), .i_xfer_len(i_xfer_len),
    .o_busy(o_busy), .o_done_stb(o_done_stb), .o_truncated(o_truncated),
    .o_word_count(o_word_count), .o_num_reads(o_num_reads), .o_num_writes(o_num_writes),
    .i_bram_we(i_bram_we), .i_bram_addr(i_bram_addr), .i_bram_din(i_bram_din),
    .o_bram_dout(o_bram_dout), .o_bram_valid(o_bram_valid),
    .i_write_ready(i_write_ready), .o_write_activate(o_write_activate),
    .i_write_size(i_write_size), .o_write_stb(o_write_stb), .o_write_data(o_write_data),
    .i_read_ready(i_read_ready), .o_read_activate(o_read_activate),
    .i_read_size(i_read_size), .i_read_data(i_read_data), .o_read_stb(o_read_stb)
  );

  always #5 clk = ~clk;

  // Bench-side PPFIFO models and event recorders
  int          cyc = 0;
  int          rd_idx = 0;
  logic [31:0] rd_src [8];
  logic [31:0] wq [$];
  int          first_act_cyc, first_stb_cyc, act_rises, rd_stb_cnt, done_cnt;
  logic [1:0]  prev_act = 2'b00;
  logic [1:0]  last_act;

  assign i_read_data = rd_src[rd_idx % 8];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_read_stb) rd_idx <= rd_idx + 1;
  end

  always @(negedge clk) begin
    if (o_write_stb) begin
      wq.push_back(o_write_data);
      if (first_stb_cyc < 0) first_stb_cyc = cyc;
    end
    if (o_write_activate != 2'b00) begin
      if (first_act_cyc < 0) first_act_cyc = cyc;
      last_act = o_write_activate;
    end
    if (o_write_activate != 2'b00 && prev_act == 2'b00) act_rises++;
    prev_act = o_write_activate;
    if (o_read_stb) rd_stb_cnt++;
    if (o_done_stb) done_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon;
    wq.delete();
    first_act_cyc = -1;
    first_stb_cyc = -1;
    act_rises = 0;
    rd_stb_cnt = 0;
  endtask

  task automatic start_xfer(input logic wr, input logic rd, input int base, input int len);
    i_base_addr = MD'(base);
    i_xfer_len = (MD+1)'(len);
    i_start_wr_stb = wr;
    i_start_rd_stb = rd;
    tick();
    i_start_wr_stb = 1'b0;
    i_start_rd_stb = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (o_done_stb) begin seen = 1; break; end
      tick();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done_timeout got=0 want=1", name);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({o_busy, o_done_stb, o_truncated, o_write_stb, o_read_stb, o_read_activate} !== 6'b0 ||
        o_write_activate !== 2'b00 || o_word_count !== '0 || o_num_reads !== 32'd0 ||
        o_num_writes !== 32'd0 || o_write_data !== '0 || o_bram_dout !== '0) begin
      errors++;
      $display("FAIL reset_outputs busy=%b wact=%b wc=%0d nr=%0d nw=%0d want all zero",
               o_busy, o_write_activate, o_word_count, o_num_reads, o_num_writes);
    end
    checks++;
    if (o_bram_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_valid got=%b want=1", o_bram_valid);
    end
  endtask

  task automatic preload;
    for (int i = 0; i < 16; i++) begin
      i_bram_we = 1'b1;
      i_bram_addr = MD'(i);
      i_bram_din = PRE + 32'(i);
      tick();
    end
    i_bram_we = 1'b0;
    i_bram_addr = '0;
    tick();
  endtask

  task automatic test_single_buffer;
    clear_mon();
    i_write_ready = 2'b01;
    i_write_size = 24'd8;
    start_xfer(1'b1, 1'b0, 0, 5);
    checks++;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL wr1_busy got=%b want=1", o_busy); end
    wait_done("wr1");
    tick();
    checks++;
    if (o_num_writes !== 32'd1 || o_word_count !== 5'd5 || o_busy !== 1'b0 || o_write_activate !== 2'b00) begin
      errors++;
      $display("FAIL wr1_status nw=%0d wc=%0d busy=%b act=%b want 1 5 0 00",
               o_num_writes, o_word_count, o_busy, o_write_activate);
    end
    checks++;
    if (first_stb_cyc - first_act_cyc !== 2) begin
      errors++;
      $display("FAIL wr1_latency got=%0d want=2", first_stb_cyc - first_act_cyc);
    end
    checks++;
    if (wq.size() !== 5) begin
      errors++;
      $display("FAIL wr1_count got=%0d want=5", wq.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (wq[i] !== PRE + 32'(i)) begin
          errors++;
          $display("FAIL wr1_data[%0d] got=%h want=%h", i, wq[i], PRE + 32'(i));
        end
      end
    end
  endtask

  task automatic test_wrap_two_buffers;
    int exp_idx [6] = '{14, 15, 0, 1, 2, 3};
    clear_mon();
    i_write_ready = 2'b10;
    i_write_size = 24'd4;
    start_xfer(1'b1, 1'b0, 14, 6);
    wait_done("wr2");
    tick();
    checks++;
    if (o_num_writes !== 32'd2 || o_word_count !== 5'd6 || act_rises !== 2 || last_act !== 2'b10) begin
      errors++;
      $display("FAIL wr2_status nw=%0d wc=%0d rises=%0d act=%b want 2 6 2 10",
               o_num_writes, o_word_count, act_rises, last_act);
    end
    checks++;
    if (wq.size() !== 6) begin
      errors++;
      $display("FAIL wr2_count got=%0d want=6", wq.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (wq[i] !== PRE + 32'(exp_idx[i])) begin
          errors++;
          $display("FAIL wr2_data[%0d] got=%h want=%h", i, wq[i], PRE + 32'(exp_idx[i]));
        end
      end
    end
  endtask

  task automatic test_start_collision;
    clear_mon();
    i_write_ready = 2'b01;
    i_write_size = 24'd8;
    i_read_ready = 1'b1;
    i_read_size = 24'd4;
    start_xfer(1'b1, 1'b1, 0, 2);
    wait_done("both");
    repeat (3) tick();
    i_read_ready = 1'b0;
    checks++;
    if (o_num_writes !== 32'd3 || o_num_reads !== 32'd0 || wq.size() !== 2 || rd_stb_cnt !== 0) begin
      errors++;
      $display("FAIL both_start nw=%0d nr=%0d words=%0d pops=%0d want 3 0 2 0",
               o_num_writes, o_num_reads, wq.size(), rd_stb_cnt);
    end
  endtask

  task automatic test_read_truncate;
    logic [31:0] exp_mem [4];
    clear_mon();
    for (int i = 0; i < 8; i++) rd_src[i] = 32'hBEEF_0000 + 32'(i);
    i_read_ready = 1'b1;
    i_read_size = 24'd5;
    start_xfer(1'b0, 1'b1, 5, 3);
    wait_done("rd");
    i_read_ready = 1'b0;
    tick();
    checks++;
    if (o_num_reads !== 32'd1 || o_truncated !== 1'b1 || o_word_count !== 5'd3 ||
        rd_stb_cnt !== 5 || o_read_activate !== 1'b0) begin
      errors++;
      $display("FAIL rd_status nr=%0d trunc=%b wc=%0d pops=%0d act=%b want 1 1 3 5 0",
               o_num_reads, o_truncated, o_word_count, rd_stb_cnt, o_read_activate);
    end
    exp_mem = '{32'hBEEF_0000, 32'hBEEF_0001, 32'hBEEF_0002, PRE + 32'd8};
    for (int i = 0; i < 4; i++) begin
      i_bram_addr = MD'(5 + i);
      repeat (3) tick();
      checks++;
      if (o_bram_dout !== exp_mem[i]) begin
        errors++;
        $display("FAIL rd_mem[%0d] got=%h want=%h", 5 + i, o_bram_dout, exp_mem[i]);
      end
    end
    i_bram_addr = '0;
    repeat (3) tick();
  endtask

  task automatic test_cancel;
    int done_before;
    bit act_seen = 0;
    clear_mon();
    i_write_ready = 2'b01;
    i_write_size = 24'd8;
    start_xfer(1'b1, 1'b0, 0, 8);
    for (int i = 0; i < 20; i++) begin
      if (o_write_activate != 2'b00) begin act_seen = 1; break; end
      tick();
    end
    checks++;
    if (!act_seen) begin errors++; $display("FAIL cancel_act_timeout got=0 want=1"); end
    done_before = done_cnt;
    i_cancel_stb = 1'b1;
    tick();
    i_cancel_stb = 1'b0;
    checks++;
    if (o_write_activate !== 2'b00 || o_busy !== 1'b0 || o_write_stb !== 1'b0) begin
      errors++;
      $display("FAIL cancel_next act=%b busy=%b stb=%b want 00 0 0", o_write_activate, o_busy, o_write_stb);
    end
    repeat (10) tick();
    checks++;
    if (done_cnt !== done_before || o_num_writes !== 32'd3 || wq.size() !== 0) begin
      errors++;
      $display("FAIL cancel_quiet dones=%0d nw=%0d words=%0d want %0d 3 0",
               done_cnt, o_num_writes, wq.size(), done_before);
    end
    clear_mon();
    start_xfer(1'b1, 1'b0, 2, 3);
    wait_done("after_cancel");
    tick();
    checks++;
    if (o_num_writes !== 32'd4 || wq.size() !== 3) begin
      errors++;
      $display("FAIL after_cancel nw=%0d words=%0d want 4 3", o_num_writes, wq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wq[i] !== PRE + 32'(2 + i)) begin
          errors++;
          $display("FAIL after_cancel_data[%0d] got=%h want=%h", i, wq[i], PRE + 32'(2 + i));
        end
      end
    end
  endtask

  task automatic test_bram_valid;
    logic [2:0] exp_v;
    logic [2:0] got_v;
`ifdef ADAPTER_DPB_XFER_BRAM_VALID_EN
    exp_v = 3'b100;
`else
    exp_v = 3'b111;
`endif
    tick();
    i_bram_addr = MD'(3);
    #1;
    got_v[0] = o_bram_valid;
    tick();
    got_v[1] = o_bram_valid;
    tick();
    got_v[2] = o_bram_valid;
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL bram_valid seq got=%b want=%b", got_v, exp_v);
    end
    checks++;
    if (o_bram_dout !== PRE + 32'd3) begin
      errors++;
      $display("FAIL bram_dout got=%h want=%h", o_bram_dout, PRE + 32'd3);
    end
  endtask

  initial begin
    rst = 1'b1;
    i_start_wr_stb = 1'b0; i_start_rd_stb = 1'b0; i_cancel_stb = 1'b0;
    i_base_addr = '0; i_xfer_len = '0;
    i_bram_we = 1'b0; i_bram_addr = '0; i_bram_din = '0;
    i_write_ready = 2'b00; i_write_size = '0;
    i_read_ready = 1'b0; i_read_size = '0;
    for (int i = 0; i < 8; i++) rd_src[i] = '0;
    done_cnt = 0;
    last_act = 2'b00;
    clear_mon();
    test_reset();
    preload();
    test_single_buffer();
    test_wrap_two_buffers();
    test_start_collision();
    test_read_truncate();
    test_cancel();
    test_bram_valid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adapter_dpb_ppfifo_xfer.md
Name: adapter_dpb_ppfifo_xfer

Overview:
Single-clock, parametrised successor to the BRAM/ping-pong FIFO adapter.
- Owns a dual-port block RAM: port A is user-facing, port B is driven by an internal transfer engine.
- The engine moves programmable-length, base-addressed blocks in either direction: memory -> write PPFIFO, or read PPFIFO -> memory.
- Transfers span multiple ping-pong buffers, tolerate configurable RAM read latency, and report completion and truncation.
- Clock-domain crossing is done outside this block.

Parameters:
- MEM_DEPTH, 10, address width; MEM_SIZE = 2**MEM_DEPTH words.
- DATA_WIDTH, 32, word width.
- MEM_LATENCY, 2, port-B read latency in cycles (range 1..4).
- SIZE_WIDTH, 24, width of the PPFIFO size ports.

Ports:
- clk  in  1  clock for the whole block, including both RAM ports.
- rst  in  1  synchronous, active-high reset.
- i_start_wr_stb  in  1  start a memory -> PPFIFO transfer.
- i_start_rd_stb  in  1  start a PPFIFO -> memory transfer.
- i_cancel_stb  in  1  abort the current transfer.
- i_base_addr  in  MEM_DEPTH  first memory word of the transfer.
- i_xfer_len  in  MEM_DEPTH+1  words to transfer.
- o_busy  out  1  transfer in progress.
- o_done_stb  out  1  one-cycle pulse when a transfer completes.
- o_truncated  out  1  sticky flag: words discarded on the last read.
- o_word_count  out  MEM_DEPTH+1  words moved in the current/last transfer.
- o_num_reads  out  32  completed read transfers.
- o_num_writes  out  32  completed write transfers.
- i_bram_we  in  1  user port write enable.
- i_bram_addr  in  MEM_DEPTH  user port address.
- i_bram_din  in  DATA_WIDTH  user port write data.
- o_bram_dout  out  DATA_WIDTH  user port read data.
- o_bram_valid  out  1  o_bram_dout is valid for i_bram_addr.
- i_write_ready  in  2  write PPFIFO buffer ready flags.
- o_write_activate  out  2  write PPFIFO buffer activate.
- i_write_size  in  SIZE_WIDTH  write PPFIFO buffer capacity.
- o_write_stb  out  1  write PPFIFO strobe.
- o_write_data  out  DATA_WIDTH  write PPFIFO data.
- i_read_ready  in  1  read PPFIFO packet ready.
- o_read_activate  out  1  read PPFIFO activate.
- i_read_size  in  SIZE_WIDTH  read PPFIFO packet size.
- i_read_data  in  DATA_WIDTH  read PPFIFO data.
- o_read_stb  out  1  read PPFIFO pop strobe.

Behaviour:
- Reset values: every output is 0, state is IDLE, and o_truncated is cleared. The exception is o_bram_valid (see Optional Feature).
- Length rule: len = min(i_xfer_len, MEM_SIZE), latched on start. The engine address increments modulo MEM_SIZE, so transfers wrap past the top of memory.
- Start rules:
  - Starts are accepted only in IDLE; otherwise ignored.
  - Simultaneous write and read starts: write wins, read is ignored.
  - len == 0: go straight to DONE.
- States: IDLE, WR_SETUP, WR_ISSUE, WR_DRAIN, RD_SETUP, RD_XFER, DONE.
- WR_SETUP:
  - Waits for i_write_ready != 0 with o_write_activate == 0.
  - Activates bit 0 if i_write_ready[0] is set, else bit 1.
  - Latches chunk = min(remaining, i_write_size), then goes to WR_ISSUE.
- WR_ISSUE:
  - Issues one port-B address per cycle for chunk cycles.
  - A MEM_LATENCY-deep valid shift register produces o_write_stb exactly MEM_LATENCY cycles after each address issue.
  - o_write_data comes straight from RAM.
- WR_DRAIN:
  - Waits for the valid pipeline to empty, then clears o_write_activate.
  - Goes to WR_SETUP if remaining > 0, else DONE.
- RD_SETUP: on i_read_ready with !o_read_activate, asserts o_read_activate and latches pkt = i_read_size.
- RD_XFER:
  - Every cycle while pkt > 0: o_read_stb = 1, port-B write of i_read_data at the current address, address+1, remaining-1.
  - Once remaining reaches 0, further packet words are popped without a write and o_truncated is set.
  - At packet end: deactivate, then go to RD_SETUP if remaining > 0, else DONE.
  - A packet with i_read_size == 0 is released immediately.
- DONE (one cycle):
  - o_done_stb = 1.
  - Increments o_num_writes or o_num_reads.
  - Returns to IDLE.
- Status: o_busy = (state != IDLE). o_word_count is cleared on start and increments per word written to the PPFIFO or to RAM.
- Cancel:
  - i_cancel_stb has priority over everything.
  - Next cycle: both activates = 0, strobes = 0, valid pipeline flushed, state = IDLE.
  - No o_done_stb, counters unchanged.
- Port A is independent of the engine. Port-A and port-B writes to the same address in the same cycle are undefined; software must avoid them.

Optional Feature:
- Macro: ADAPTER_DPB_XFER_BRAM_VALID_EN.
- Defined: o_bram_valid is 1 only when i_bram_addr has been stable for MEM_LATENCY cycles since its last change, tracked with a saturating counter. Reset state is valid, with the counter saturated.
- Undefined: o_bram_valid is tied to 1 and the tracker is not built.

Decomposition:
- Shared package adapter_dpb_xfer_pkg holds:
  - the state encoding constants;
  - MEM_LATENCY bounds;
  - a min-width helper function.
- The existing dpb RAM is reused.
- One sub-module: adapter_dpb_rd_pipe, the MEM_LATENCY valid shift register with flush input.

Test Plan:
- MEM_DEPTH=4, base 0, len 5, i_write_size 8: one buffer; 5 o_write_stb pulses, first 2 cycles after the first address issue; data = RAM[0..4]; o_num_writes = 1.
- base 14, len 6, i_write_size 4: two buffers of 4 and 2 words; data = RAM[14,15,0,1,2,3]; address wraps correctly.
- Read, len 3, packet size 5: RAM[b..b+2] written; 5 o_read_stb pulses; o_truncated = 1; o_word_count = 3.
- i_start_wr_stb and i_start_rd_stb in the same cycle -> write performed; read start dropped; o_num_reads stays 0.
- i_cancel_stb mid WR_ISSUE -> next cycle activates = 0, o_busy = 0, no o_done_stb; a subsequent start works normally.
- With the macro defined: change i_bram_addr -> o_bram_valid low for exactly MEM_LATENCY cycles. With the macro undefined: o_bram_valid is constant 1.
